// File: rtl/gigatron_bus_core.sv
// gigatron_bus_core
//   Gigatron-style 8-bit CPU core with a ROM fetch port and an asynchronous-read
//   RAM port. One word is fetched per advance cycle (i_rom_valid=1); the word
//   fetched in the previous advance executes in the same cycle, so every branch
//   has one delay slot.
// Ports:
//   i_clock, i_reset      clock and synchronous active-high reset
//   o_rom_addr            current PC
//   i_rom_data            fetched word {D operand, opcode}
//   i_rom_valid           fetch word valid; a high level is one advance
//   o_ram_addr            RAM address (RAM_AW bits), combinational
//   i_ram_rdata           RAM read data for o_ram_addr, same cycle
//   o_ram_wdata, o_ram_we RAM write data and strobe (write on the clock edge)
//   i_in                  controller input, captured while OUT[7]=1
//   o_out, o_xout         OUT and XOUT registers
//   o_retire              high in each advance cycle that executes an instruction
module gigatron_bus_core #(
  parameter int unsigned RAM_AW    = 15,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter bit          XOUT_EDGE = 1'b0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  output logic [15:0]       o_rom_addr,
  input  logic [15:0]       i_rom_data,
  input  logic              i_rom_valid,
  output logic [RAM_AW-1:0] o_ram_addr,
  input  logic [7:0]        i_ram_rdata,
  output logic [7:0]        o_ram_wdata,
  output logic              o_ram_we,
  input  logic [7:0]        i_in,
  output logic [7:0]        o_out,
  output logic [7:0]        o_xout,
  output logic              o_retire
);

  localparam logic [2:0] OP_LD  = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_ST  = 3'd6;
  localparam logic [2:0] OP_BCC = 3'd7;

  logic [15:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d, d_q, d_d;
  logic [7:0]  ir_hi_q, ir_hi_d;   // PC high byte the held instruction was fetched from
  logic        ir_v_q, ir_v_d;
  logic [7:0]  ac_q, ac_d, x_q, x_d, y_q, y_d;
  logic [7:0]  out_q, out_d, xout_q, xout_d, in_q, in_d;
  logic        out6_q, out6_d;

  logic [2:0]  op, mode;
  logic [1:0]  bus;
  logic        is_bcc, is_st, exec, cond, xout_load;
  logic [7:0]  addr_hi, addr_lo, bus_val, alu;
  logic signed [7:0] ac_s;

  assign ac_s = ac_q;

  always_comb begin
    op     = ir_q[7:5];
    mode   = ir_q[4:2];
    bus    = ir_q[1:0];
    is_bcc = (op == OP_BCC);
    is_st  = (op == OP_ST);
    exec   = i_rom_valid && ir_v_q && !i_reset;

    // Branches always read RAM at [D] with a zero high byte.
    addr_hi = 8'h00;
    addr_lo = d_q;
    if (!is_bcc) begin
      if (mode == 3'd2 || mode == 3'd3 || mode == 3'd7) addr_hi = y_q;
      if (mode == 3'd1 || mode == 3'd3 || mode == 3'd7) addr_lo = x_q;
    end
    o_ram_addr = RAM_AW'({addr_hi, addr_lo});

    case (bus)
      2'd0:    bus_val = d_q;
      2'd1:    bus_val = i_ram_rdata;
      2'd2:    bus_val = ac_q;
      default: bus_val = in_q;
    endcase

    case (op)
      OP_LD:   alu = bus_val;
      OP_AND:  alu = ac_q & bus_val;
      OP_OR:   alu = ac_q | bus_val;
      OP_XOR:  alu = ac_q ^ bus_val;
      OP_ADD:  alu = ac_q + bus_val;
      OP_SUB:  alu = ac_q - bus_val;
      default: alu = bus_val;
    endcase

    case (mode)
      3'd1:    cond = (ac_s > 8'sd0);
      3'd2:    cond = (ac_s < 8'sd0);
      3'd3:    cond = (ac_q != 8'h00);
      3'd4:    cond = (ac_q == 8'h00);
      3'd5:    cond = (ac_s >= 8'sd0);
      3'd6:    cond = (ac_s <= 8'sd0);
      default: cond = 1'b1;
    endcase

    if (XOUT_EDGE) xout_load = out_q[6] && !out6_q;
    else           xout_load = out_q[6];

    o_rom_addr  = pc_q;
    o_ram_wdata = bus_val;
    o_ram_we    = exec && is_st;
    o_retire    = exec;
    o_out       = out_q;
    o_xout      = xout_q;
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    d_d     = d_q;
    ir_hi_d = ir_hi_q;
    ir_v_d  = ir_v_q;
    ac_d    = ac_q;
    x_d     = x_q;
    y_d     = y_q;
    out_d   = out_q;
    xout_d  = xout_q;
    in_d    = in_q;
    out6_d  = out6_q;
    if (i_rom_valid) begin
      ir_d    = i_rom_data[7:0];
      d_d     = i_rom_data[15:8];
      ir_hi_d = pc_q[15:8];
      ir_v_d  = 1'b1;
      pc_d    = pc_q + 16'd1;
      out6_d  = out_q[6];
      if (out_q[7])  in_d   = i_in;
      if (xout_load) xout_d = ac_q;
      if (ir_v_q) begin
        if (is_bcc) begin
          if (mode == 3'd0)  pc_d = {y_q, bus_val};
          else if (cond)     pc_d = {ir_hi_q, bus_val};
        end else begin
          case (mode)
            3'd4:       x_d = alu;
            3'd5:       y_d = alu;
            3'd6, 3'd7: if (!is_st) out_d = alu;
            default:    if (!is_st) ac_d  = alu;
          endcase
          if (mode == 3'd7) x_d = x_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc_q   <= RESET_PC;
      ir_v_q <= 1'b0;
      ac_q   <= 8'h00;
      x_q    <= 8'h00;
      y_q    <= 8'h00;
      out_q  <= 8'h00;
      xout_q <= 8'h00;
      in_q   <= 8'h00;
      out6_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ir_v_q <= ir_v_d;
      ac_q   <= ac_d;
      x_q    <= x_d;
      y_q    <= y_d;
      out_q  <= out_d;
      xout_q <= xout_d;
      in_q   <= in_d;
      out6_q <= out6_d;
    end
  end

  // Instruction word registers carry no meaning while IR_V=0, so they need no reset.
  always_ff @(posedge i_clock) begin
    ir_q    <= ir_d;
    d_q     <= d_d;
    ir_hi_q <= ir_hi_d;
  end

endmodule

// File: tb/tb_gigatron_bus_core.sv
module tb_gigatron_bus_core;

  logic        clk = 1'b0;
  logic        rst, vld;
  logic [7:0]  in_v;

  logic [15:0] rom_addr_e, rom_data_e, rom_addr_l, rom_data_l;
  logic [14:0] ram_addr_e, ram_addr_l;
  logic [7:0]  ram_rdata_e, ram_wdata_e, out_e, xout_e;
  logic [7:0]  ram_rdata_l, ram_wdata_l, out_l, xout_l;
  logic        ram_we_e, retire_e, ram_we_l, retire_l;

  logic [15:0] rom [0:65535];
  logic [7:0]  ram_e [0:32767];
  logic [7:0]  ram_l [0:32767];

  logic [14:0] wr_a [0:255];
  logic [7:0]  wr_d [0:255];
  int          wr_n = 0;
  int          ret_n = 0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gigatron_bus_core #(.RAM_AW(15), .RESET_PC(16'h1234), .XOUT_EDGE(1'b1)) u_edge (
    .i_clock(clk), .i_reset(rst),
    .o_rom_addr(rom_addr_e), .i_rom_data(rom_data_e), .i_rom_valid(vld),
    .o_ram_addr(ram_addr_e), .i_ram_rdata(ram_rdata_e),
    .o_ram_wdata(ram_wdata_e), .o_ram_we(ram_we_e),
    .i_in(in_v), .o_out(out_e), .o_xout(xout_e), .o_retire(retire_e)
  );

  gigatron_bus_core #(.RAM_AW(15), .RESET_PC(16'h1234), .XOUT_EDGE(1'b0)) u_lvl (
    .i_clock(clk), .i_reset(rst),
    .o_rom_addr(rom_addr_l), .i_rom_data(rom_data_l), .i_rom_valid(vld),
    .o_ram_addr(ram_addr_l), .i_ram_rdata(ram_rdata_l),
    .o_ram_wdata(ram_wdata_l), .o_ram_we(ram_we_l),
    .i_in(in_v), .o_out(out_l), .o_xout(xout_l), .o_retire(retire_l)
  );

  assign rom_data_e  = rom[rom_addr_e];
  assign rom_data_l  = rom[rom_addr_l];
  assign ram_rdata_e = ram_e[ram_addr_e];
  assign ram_rdata_l = ram_l[ram_addr_l];

  always @(posedge clk) begin
    if (ram_we_e) ram_e[ram_addr_e] <= ram_wdata_e;
    if (ram_we_l) ram_l[ram_addr_l] <= ram_wdata_l;
  end

  // Write and retire log of u_edge, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_we_e) begin
      wr_a[wr_n] <= ram_addr_e;
      wr_d[wr_n] <= ram_wdata_e;
      wr_n       <= wr_n + 1;
    end
    if (retire_e) ret_n <= ret_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 65536; i++) rom[i] = 16'h0002;  // LD AC -> AC
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset();
    run(3);
    rst = 1'b1;
    #1;
    n_checks++; if (retire_e !== 1'b0) begin n_errors++; $display("FAIL reset_retire_gate: got %b expected 0", retire_e); end
    n_checks++; if (ram_we_e !== 1'b0) begin n_errors++; $display("FAIL reset_we_gate: got %b expected 0", ram_we_e); end
    tick();
    tick();
    n_checks++; if (rom_addr_e !== 16'h1234) begin n_errors++; $display("FAIL reset_pc: got %h expected 1234", rom_addr_e); end
    n_checks++; if (out_e !== 8'h00) begin n_errors++; $display("FAIL reset_out: got %h expected 00", out_e); end
    n_checks++; if (xout_e !== 8'h00) begin n_errors++; $display("FAIL reset_xout: got %h expected 00", xout_e); end
    rst = 1'b0;
    #1;
    n_checks++; if (retire_e !== 1'b0) begin n_errors++; $display("FAIL first_adv_retire: got %b expected 0", retire_e); end
    tick();
    n_checks++; if (rom_addr_e !== 16'h1235) begin n_errors++; $display("FAIL first_adv_pc: got %h expected 1235", rom_addr_e); end
    n_checks++; if (retire_e !== 1'b1) begin n_errors++; $display("FAIL second_adv_retire: got %b expected 1", retire_e); end
  endtask

  task automatic test_alu_store();
    int base;
    clear_rom();
    rom[16'h1234] = 16'h0500;  // LD $05
    rom[16'h1235] = 16'hFD80;  // ADD $FD
    rom[16'h1236] = 16'h10C2;  // ST AC,[$10]
    do_reset();
    base = wr_n;
    run(3);
    n_checks++; if (ram_we_e !== 1'b1) begin n_errors++; $display("FAIL st_we: got %b expected 1", ram_we_e); end
    n_checks++; if (ram_addr_e !== 15'h0010) begin n_errors++; $display("FAIL st_addr: got %h expected 0010", ram_addr_e); end
    n_checks++; if (ram_wdata_e !== 8'h02) begin n_errors++; $display("FAIL st_wdata: got %h expected 02", ram_wdata_e); end
    run(1);
    n_checks++; if (ram_we_e !== 1'b0) begin n_errors++; $display("FAIL st_we_after: got %b expected 0", ram_we_e); end
    n_checks++; if (wr_n - base !== 1) begin n_errors++; $display("FAIL st_count: got %0d expected 1", wr_n - base); end
    n_checks++; if (ram_e[16] !== 8'h02) begin n_errors++; $display("FAIL st_mem: got %h expected 02", ram_e[16]); end
  endtask

  task automatic test_alu_ops();
    clear_rom();
    rom[16'h1234] = 16'hF000;  // LD $F0
    rom[16'h1235] = 16'h3C20;  // AND $3C -> 30
    rom[16'h1236] = 16'h001A;  // LD AC -> OUT
    rom[16'h1237] = 16'h0540;  // OR $05  -> 35
    rom[16'h1238] = 16'h001A;
    rom[16'h1239] = 16'hFF60;  // XOR $FF -> CA
    rom[16'h123A] = 16'h001A;
    rom[16'h123B] = 16'hCBA0;  // SUB $CB -> FF
    rom[16'h123C] = 16'h001A;
    do_reset();
    run(4);
    n_checks++; if (out_e !== 8'h30) begin n_errors++; $display("FAIL alu_and: got %h expected 30", out_e); end
    run(2);
    n_checks++; if (out_e !== 8'h35) begin n_errors++; $display("FAIL alu_or: got %h expected 35", out_e); end
    run(2);
    n_checks++; if (out_e !== 8'hCA) begin n_errors++; $display("FAIL alu_xor: got %h expected CA", out_e); end
    run(2);
    n_checks++; if (out_e !== 8'hFF) begin n_errors++; $display("FAIL alu_sub_wrap: got %h expected FF", out_e); end
  endtask

  task automatic test_addr_trunc();
    clear_rom();
    rom[16'h1234] = 16'hFF10;  // LD $FF -> X
    rom[16'h1235] = 16'hFF14;  // LD $FF -> Y
    rom[16'h1236] = 16'h9CCC;  // ST $9C,[Y,X]
    rom[16'h1237] = 16'h000D;  // LD [Y,X]
    rom[16'h1238] = 16'h001A;  // LD AC -> OUT
    do_reset();
    run(3);
    n_checks++; if (ram_addr_e !== 15'h7FFF) begin n_errors++; $display("FAIL trunc_st_addr: got %h expected 7FFF", ram_addr_e); end
    n_checks++; if (ram_wdata_e !== 8'h9C) begin n_errors++; $display("FAIL trunc_st_wdata: got %h expected 9C", ram_wdata_e); end
    run(1);
    n_checks++; if (ram_addr_e !== 15'h7FFF) begin n_errors++; $display("FAIL trunc_ld_addr: got %h expected 7FFF", ram_addr_e); end
    n_checks++; if (ram_we_e !== 1'b0) begin n_errors++; $display("FAIL trunc_ld_we: got %b expected 0", ram_we_e); end
    run(2);
    n_checks++; if (out_e !== 8'h9C) begin n_errors++; $display("FAIL ram_bus_read: got %h expected 9C", out_e); end
  endtask

  task automatic test_branch();
    clear_rom();
    rom[16'h1234] = 16'h0214;  // LD $02 -> Y
    rom[16'h1235] = 16'hFFE0;  // JMP far Y:$FF
    rom[16'h02FF] = 16'h40FC;  // BRA $40
    rom[16'h0300] = 16'h1100;  // LD $11 (delay slot)
    rom[16'h0240] = 16'h001A;  // LD AC -> OUT
    rom[16'h0340] = 16'hEE18;  // LD $EE -> OUT (wrong page)
    do_reset();
    run(3);
    n_checks++; if (rom_addr_e !== 16'h02FF) begin n_errors++; $display("FAIL far_jump: got %h expected 02FF", rom_addr_e); end
    run(2);
    n_checks++; if (rom_addr_e !== 16'h0240) begin n_errors++; $display("FAIL near_jump_page: got %h expected 0240", rom_addr_e); end
    run(2);
    n_checks++; if (out_e !== 8'h11) begin n_errors++; $display("FAIL delay_slot: got %h expected 11", out_e); end
  endtask

  task automatic test_cond();
    clear_rom();
    rom[16'h1234] = 16'h8000;  // LD $80
    rom[16'h1235] = 16'h50E4;  // BGT $50 (not taken)
    rom[16'h1237] = 16'h60E8;  // BLT $60 (taken)
    rom[16'h1260] = 16'h0000;  // LD $00
    rom[16'h1261] = 16'h70F0;  // BEQ $70 (taken)
    do_reset();
    run(3);
    n_checks++; if (rom_addr_e !== 16'h1237) begin n_errors++; $display("FAIL bgt_not_taken: got %h expected 1237", rom_addr_e); end
    run(2);
    n_checks++; if (rom_addr_e !== 16'h1260) begin n_errors++; $display("FAIL blt_taken: got %h expected 1260", rom_addr_e); end
    run(3);
    n_checks++; if (rom_addr_e !== 16'h1270) begin n_errors++; $display("FAIL beq_taken: got %h expected 1270", rom_addr_e); end
  endtask

  task automatic test_xout();
    clear_rom();
    rom[16'h1234] = 16'h5A00;  // LD $5A
    rom[16'h1235] = 16'h4018;  // LD $40 -> OUT
    rom[16'h1236] = 16'hA100;  // LD $A1
    rom[16'h1237] = 16'hA200;  // LD $A2
    rom[16'h1238] = 16'hA300;  // LD $A3
    rom[16'h1239] = 16'h0018;  // LD $00 -> OUT
    do_reset();
    run(4);
    n_checks++; if (xout_e !== 8'h5A) begin n_errors++; $display("FAIL xout_edge_first: got %h expected 5A", xout_e); end
    n_checks++; if (xout_l !== 8'h5A) begin n_errors++; $display("FAIL xout_level_first: got %h expected 5A", xout_l); end
    run(4);
    n_checks++; if (xout_e !== 8'h5A) begin n_errors++; $display("FAIL xout_edge_hold: got %h expected 5A", xout_e); end
    n_checks++; if (xout_l !== 8'hA3) begin n_errors++; $display("FAIL xout_level_last: got %h expected A3", xout_l); end
  endtask

  task automatic test_in();
    clear_rom();
    rom[16'h1234] = 16'h8018;  // LD $80 -> OUT
    rom[16'h1236] = 16'h001B;  // LD IN -> OUT
    in_v = 8'h3C;
    do_reset();
    run(3);
    n_checks++; if (out_e !== 8'h80) begin n_errors++; $display("FAIL in_out7: got %h expected 80", out_e); end
    run(1);
    n_checks++; if (out_e !== 8'h3C) begin n_errors++; $display("FAIL in_capture: got %h expected 3C", out_e); end
    in_v = 8'h00;
  endtask

  task automatic test_back_to_back();
    logic [14:0] ea [4];
    logic [7:0]  ed [4];
    int base;
    int rbase;
    ea = '{15'h0010, 15'h0011, 15'h0012, 15'h0013};
    ed = '{8'h07, 8'h08, 8'h09, 8'h09};
    clear_rom();
    rom[16'h1234] = 16'h0014;  // LD $00 -> Y
    rom[16'h1235] = 16'h1010;  // LD $10 -> X
    rom[16'h1236] = 16'h0700;  // LD $07
    rom[16'h1237] = 16'h00DE;  // ST AC,[Y,X++]
    rom[16'h1238] = 16'h0180;  // ADD $01
    rom[16'h1239] = 16'h00DE;
    rom[16'h123A] = 16'h0180;
    rom[16'h123B] = 16'h00DE;
    rom[16'h123C] = 16'h00C6;  // ST AC,[X]
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      base  = wr_n;
      rbase = ret_n;
      if (pass == 0) begin
        run(10);
      end else begin
        for (int c = 0; c < 30; c++) begin
          vld = (c % 3 == 2);
          #1;
          if (!vld) begin
            n_checks++; if (ram_we_e !== 1'b0) begin n_errors++; $display("FAIL stall_we c=%0d: got %b expected 0", c, ram_we_e); end
          end
          tick();
        end
        vld = 1'b0;
      end
      n_checks++; if (wr_n - base !== 4) begin n_errors++; $display("FAIL b2b_count pass=%0d: got %0d expected 4", pass, wr_n - base); end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (wr_a[base+k] !== ea[k] || wr_d[base+k] !== ed[k]) begin
          n_errors++;
          $display("FAIL b2b_write pass=%0d k=%0d: got %h/%h expected %h/%h", pass, k, wr_a[base+k], wr_d[base+k], ea[k], ed[k]);
        end
      end
      n_checks++; if (ret_n - rbase !== 9) begin n_errors++; $display("FAIL b2b_retire pass=%0d: got %0d expected 9", pass, ret_n - rbase); end
      n_checks++; if (rom_addr_e !== 16'h123E) begin n_errors++; $display("FAIL b2b_pc pass=%0d: got %h expected 123E", pass, rom_addr_e); end
    end
    vld = 1'b1;
  endtask

  initial begin
    rst  = 1'b1;
    vld  = 1'b0;
    in_v = 8'h00;
    test_reset();
    test_alu_store();
    test_alu_ops();
    test_addr_trunc();
    test_branch();
    test_cond();
    test_xout();
    test_in();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gigatron_bus_core.md
GIGATRON_BUS_CORE -- requirements
Module: gigatron_bus_core

Interface
REQ-001 Parameter RAM_AW, default 15: RAM address width in bits, legal range 8..16.
REQ-002 Parameter RESET_PC, default 16'h0000: PC value loaded at reset.
REQ-003 Parameter XOUT_EDGE, default 0: 0 = XOUT loads on every advance while OUT[6]=1; 1 = XOUT loads only on an OUT[6] 0->1 transition.
REQ-004 i_clock  in  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 o_rom_addr  out  16  current PC, driven combinationally from the PC register.
REQ-007 i_rom_data  in  16  fetched word: [15:8] = D operand, [7:0] = opcode.
REQ-008 i_rom_valid  in  1  i_rom_data is valid this cycle; its high level defines an "advance" cycle.
REQ-009 o_ram_addr  out  RAM_AW  RAM address, combinational.
REQ-010 i_ram_rdata  in  8  RAM read data for o_ram_addr, same cycle (asynchronous read).
REQ-011 o_ram_wdata / o_ram_we  out  8 / 1  write data and write strobe; the write occurs on the clock edge.
REQ-012 i_in  in  8  controller input; o_out  out  8  OUT register; o_xout  out  8  XOUT register.
REQ-013 o_retire  out  1  one-cycle pulse for each executed instruction.

Function
REQ-014 State SHALL be PC[15:0], IR[7:0], D[7:0], IR_V, AC, X, Y, OUT, XOUT, IN, and OUT6_Q (registered OUT[6]).
REQ-015 The core SHALL change no state in any cycle with i_rom_valid=0 (full stall); o_ram_we SHALL be 0 in that cycle.
REQ-016 In an advance cycle, the core SHALL latch {D,IR} <= i_rom_data and set IR_V <= 1; the held IR/D instruction executes only if IR_V=1.
REQ-017 PC on advance: taken branch -> target, otherwise PC+1 as a 16-bit increment (0xFFFF wraps to 0x0000); one branch delay slot results.
REQ-018 Decode: op=IR[7:5] (0 LD, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 ST, 7 Bcc); mode=IR[4:2]; bus=IR[1:0] (0 D, 1 RAM, 2 AC, 3 IN); B = selected bus value.
REQ-019 ALU, 8-bit modulo: LD B; AND AC&B; OR AC|B; XOR AC^B; ADD AC+B; SUB AC-B; ST passes B.
REQ-020 Non-branch modes 0..7 SHALL select addr/destination as: [D]/AC, [X]/AC, [Y,D]/AC, [Y,X]/AC, [D]/X, [D]/Y, [D]/OUT, [Y,X++]/OUT.
REQ-021 Address {hi,lo}: hi = Y for modes 2, 3 and 7, else 0; lo = X for modes 1, 3 and 7, else D; the address SHALL be truncated to RAM_AW LSBs.
REQ-022 ST SHALL drive o_ram_we=1 and o_ram_wdata=B; it writes no AC or OUT, but modes 4/5 still load X/Y with B.
REQ-023 In mode 7, any non-branch op SHALL increment X by 1 (mod 256) after use; the address uses the pre-increment X.
REQ-024 Bcc mode 0 SHALL jump far: PC <= {Y,B}.
REQ-025 Bcc modes 1..7 SHALL jump near: PC[7:0] <= B and PC[15:8] <= PC[15:8], taken when the condition holds: 1 AC>0 signed, 2 AC<0, 3 AC!=0, 4 AC==0, 5 AC>=0, 6 AC<=0, 7 always.
REQ-026 For Bcc with bus=1, the RAM address SHALL be [D] with hi=0.
REQ-027 XOUT SHALL load AC (pre-execute value) per XOUT_EDGE, evaluated on the OUT register value at the start of the advance cycle.
REQ-028 IN SHALL load i_in on an advance while OUT[7]=1.
REQ-029 o_retire SHALL be asserted combinationally for exactly the advance cycles with IR_V=1.
REQ-030 If a RAM write and a RAM read target the same address in one cycle, the read SHALL return the old data.

Reset
REQ-031 While i_reset=1: PC<=RESET_PC, IR_V<=0, OUT<=0, XOUT<=0, IN<=0, OUT6_Q<=0, AC/X/Y<=0; o_ram_we=0 and o_retire=0 in every reset cycle.
REQ-032 Reset SHALL take priority over an advance in the same cycle; the instruction in flight is discarded.

Verification
REQ-033 Reset with RESET_PC=16'h1234 held, i_rom_valid=1 -> o_rom_addr=0x1234, no retire; the first post-reset advance gives no retire and PC=0x1235.
REQ-034 Program LD $05; ADD $FD; ST [$10] with RAM_AW=15 -> AC=0x02, o_ram_we at addr 0x0010 with wdata 0x02.
REQ-035 Bcc always $40 at PC 0x02FF, followed by LD $11 -> the delay-slot LD executes (AC=0x11), then fetch at 0x0240 (near jump keeps high byte 0x02).
REQ-036 i_rom_valid toggled with a 1-in-3 pattern during a ST [Y,X++] loop -> the RAM write sequence and final X match the no-stall run, and o_retire count equals the instruction count.
REQ-037 XOUT_EDGE=1, OUT[6] held 1 for 3 instructions with AC changing each -> XOUT captures only the first AC value; with XOUT_EDGE=0 it tracks the last.
REQ-038 Y=0xFF, X=0xFF, RAM_AW=15, LD [Y,X] -> o_ram_addr=0x7FFF (truncated).
